// File: rtl/fcims_order_ctrl.sv
// fcims_order_ctrl
//   Sequential food-court order engine. Holds a unit price and a stock count
//   for each of ITEMS slots and processes sell/refund orders accepted over a
//   valid/ready handshake. The line price (price * qty) is formed by a
//   shift-add multiplier that consumes one quantity bit per cycle. One commit
//   cycle then checks the order, updates the running total and item stock,
//   and reports the result with a one-cycle done pulse.
//
// Ports
//   clk, reset_n            rising-edge clock, synchronous active-low reset
//   op_valid/op_ready       order handshake (op_ready = engine idle)
//   op_mode/op_item/op_qty  0 = sell, 1 = refund; item index; quantity
//   cfg_we/cfg_item/        write unit price and stock of one slot
//   cfg_price/cfg_stock       (idle only, ignored when an order is offered)
//   clr_total               clear running total (idle only, no order offered)
//   done, err_*             one-cycle completion pulse with error flags
//   line_price, total       last line price, running total (registered)
//   rd_item/rd_stock        combinational stock read port
module fcims_order_ctrl #(
  parameter  int ITEMS = 4,
  parameter  int PW    = 4,
  parameter  int QW    = 4,
  parameter  int TW    = 8,
  localparam int IW    = $clog2(ITEMS),
  localparam int LW    = PW + QW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic          op_mode,
  input  logic [IW-1:0] op_item,
  input  logic [QW-1:0] op_qty,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_item,
  input  logic [PW-1:0] cfg_price,
  input  logic [QW-1:0] cfg_stock,
  input  logic          clr_total,
  output logic          done,
  output logic          err_stock,
  output logic          err_ovf,
  output logic          err_unf,
  output logic          err_item,
  output logic [LW-1:0] line_price,
  output logic [TW-1:0] total,
  input  logic [IW-1:0] rd_item,
  output logic [QW-1:0] rd_stock
);

  localparam int CW  = $clog2(QW) + 1;
  localparam int TW1 = TW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_COMMIT
  } state_t;

  state_t        state_reg;
  logic [PW-1:0] price_reg [ITEMS];
  logic [QW-1:0] stock_reg [ITEMS];

  // Order latched at accept
  logic          mode_reg;
  logic [IW-1:0] item_reg;
  logic [QW-1:0] qty_reg;

  // Multiplier: qsh_reg shifts right (LSB first), mcand_reg shifts left
  logic [QW-1:0] qsh_reg;
  logic [LW-1:0] mcand_reg;
  logic [LW-1:0] acc_reg;
  logic [CW-1:0] cnt_reg;

  logic [TW-1:0] total_reg;
  logic [LW-1:0] line_reg;
  logic          done_reg;
  logic          err_stock_reg;
  logic          err_ovf_reg;
  logic          err_unf_reg;
  logic          err_item_reg;

  // Non-power-of-two ITEMS leaves index codes without a slot behind them.
  function automatic logic idx_ok(input logic [IW-1:0] idx);
    return int'(idx) < ITEMS;
  endfunction

  logic          accept;
  logic          cfg_hit;
  logic [IW-1:0] op_item_safe;
  logic          item_ok;
  logic [IW-1:0] item_safe;
  logic [QW-1:0] cur_stock;
  logic [QW:0]   stock_sum;
  logic [QW-1:0] stock_next;
  logic [TW:0]   tot_add;
  logic [TW:0]   tot_sub;
  logic          e_item;
  logic          e_stock;
  logic          e_ovf;
  logic          e_unf;
  logic          commit_ok;

  always_comb begin
    accept       = (state_reg == S_IDLE) && op_valid;
    // An offered order always takes priority over configuration.
    cfg_hit      = (state_reg == S_IDLE) && !op_valid && cfg_we && idx_ok(cfg_item);
    op_item_safe = idx_ok(op_item) ? op_item : '0;

    item_ok   = idx_ok(item_reg);
    item_safe = item_ok ? item_reg : '0;
    cur_stock = stock_reg[item_safe];
    stock_sum = {1'b0, cur_stock} + {1'b0, qty_reg};
    // One extra bit: carry flags sell overflow, borrow flags refund underflow.
    tot_add   = {1'b0, total_reg} + TW1'(acc_reg);
    tot_sub   = {1'b0, total_reg} - TW1'(acc_reg);

    e_item  = !item_ok;
    e_stock = 1'b0;
    e_ovf   = 1'b0;
    e_unf   = 1'b0;
    if (item_ok) begin
      if (!mode_reg) begin
        e_stock = qty_reg > cur_stock;
        e_ovf   = !e_stock && tot_add[TW];
      end else begin
        e_stock = stock_sum[QW];
        e_unf   = !e_stock && tot_sub[TW];
      end
    end
    commit_ok  = (state_reg == S_COMMIT) && !(e_item || e_stock || e_ovf || e_unf);
    stock_next = mode_reg ? stock_sum[QW-1:0] : (cur_stock - qty_reg);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      mode_reg      <= 1'b0;
      item_reg      <= '0;
      qty_reg       <= '0;
      qsh_reg       <= '0;
      mcand_reg     <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      total_reg     <= '0;
      line_reg      <= '0;
      done_reg      <= 1'b0;
      err_stock_reg <= 1'b0;
      err_ovf_reg   <= 1'b0;
      err_unf_reg   <= 1'b0;
      err_item_reg  <= 1'b0;
      for (int i = 0; i < ITEMS; i++) begin
        price_reg[i] <= '0;
        stock_reg[i] <= '0;
      end
    end else begin
      done_reg      <= 1'b0;
      err_stock_reg <= 1'b0;
      err_ovf_reg   <= 1'b0;
      err_unf_reg   <= 1'b0;
      err_item_reg  <= 1'b0;

      if (cfg_hit) begin
        price_reg[cfg_item] <= cfg_price;
        stock_reg[cfg_item] <= cfg_stock;
      end
      if (commit_ok) begin
        stock_reg[item_safe] <= stock_next;
      end

      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            mode_reg  <= op_mode;
            item_reg  <= op_item;
            qty_reg   <= op_qty;
            qsh_reg   <= op_qty;
            mcand_reg <= LW'(price_reg[op_item_safe]);
            acc_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= S_MUL;
          end else if (clr_total) begin
            total_reg <= '0;
          end
        end
        S_MUL: begin
          if (qsh_reg[0]) begin
            acc_reg <= acc_reg + mcand_reg;
          end
          mcand_reg <= mcand_reg << 1;
          qsh_reg   <= qsh_reg >> 1;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(QW - 1)) begin
            state_reg <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          done_reg      <= 1'b1;
          err_item_reg  <= e_item;
          err_stock_reg <= e_stock;
          err_ovf_reg   <= e_ovf;
          err_unf_reg   <= e_unf;
          line_reg      <= e_item ? '0 : acc_reg;
          if (commit_ok) begin
            total_reg <= mode_reg ? tot_sub[TW-1:0] : tot_add[TW-1:0];
          end
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_stock = idx_ok(rd_item) ? stock_reg[rd_item] : '0;
  end

  assign op_ready   = (state_reg == S_IDLE);
  assign done       = done_reg;
  assign err_stock  = err_stock_reg;
  assign err_ovf    = err_ovf_reg;
  assign err_unf    = err_unf_reg;
  assign err_item   = err_item_reg;
  assign line_price = line_reg;
  assign total      = total_reg;

endmodule

// File: tb/tb_fcims_order_ctrl.sv
// Bench for fcims_order_ctrl: two instances share every input, one with
// ITEMS=4 and one with ITEMS=3 (both have a 2-bit item index), so the
// out-of-range item path is exercised alongside the normal one. Each
// instance is checked against its own arithmetic model of prices, stocks
// and running total.
module tb_fcims_order_ctrl;

  localparam int QW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       op_valid;
  logic       op_mode;
  logic [1:0] op_item;
  logic [3:0] op_qty;
  logic       cfg_we;
  logic [1:0] cfg_item;
  logic [3:0] cfg_price;
  logic [3:0] cfg_stock;
  logic       clr_total;
  logic [1:0] rd_item;

  logic       o_rdy  [2];
  logic       o_done [2];
  logic       o_es   [2];
  logic       o_eo   [2];
  logic       o_eu   [2];
  logic       o_ei   [2];
  logic [7:0] o_line [2];
  logic [7:0] o_total[2];
  logic [3:0] o_rs   [2];

  fcims_order_ctrl #(.ITEMS(4), .PW(4), .QW(4), .TW(8)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .op_valid(op_valid), .op_ready(o_rdy[0]), .op_mode(op_mode),
    .op_item(op_item), .op_qty(op_qty),
    .cfg_we(cfg_we), .cfg_item(cfg_item), .cfg_price(cfg_price), .cfg_stock(cfg_stock),
    .clr_total(clr_total), .done(o_done[0]),
    .err_stock(o_es[0]), .err_ovf(o_eo[0]), .err_unf(o_eu[0]), .err_item(o_ei[0]),
    .line_price(o_line[0]), .total(o_total[0]),
    .rd_item(rd_item), .rd_stock(o_rs[0])
  );

  fcims_order_ctrl #(.ITEMS(3), .PW(4), .QW(4), .TW(8)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .op_valid(op_valid), .op_ready(o_rdy[1]), .op_mode(op_mode),
    .op_item(op_item), .op_qty(op_qty),
    .cfg_we(cfg_we), .cfg_item(cfg_item), .cfg_price(cfg_price), .cfg_stock(cfg_stock),
    .clr_total(clr_total), .done(o_done[1]),
    .err_stock(o_es[1]), .err_ovf(o_eo[1]), .err_unf(o_eu[1]), .err_item(o_ei[1]),
    .line_price(o_line[1]), .total(o_total[1]),
    .rd_item(rd_item), .rd_stock(o_rs[1])
  );

  int errors = 0;
  int checks = 0;

  // Reference model, index 0 = ITEMS 4, index 1 = ITEMS 3
  int n_items[2] = '{4, 3};
  int m_price[2][4];
  int m_stock[2][4];
  int m_total[2];
  int m_line [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_total[d] = 0;
      m_line[d]  = 0;
      for (int i = 0; i < 4; i++) begin
        m_price[d][i] = 0;
        m_stock[d][i] = 0;
      end
    end
  endtask

  // Starts at a negedge, waits one cycle, checks idle state and all stocks.
  task automatic check_idle_state(input string tag);
    int exp_s;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rd_item = 2'(i);
      #1;
      for (int d = 0; d < 2; d++) begin
        exp_s = (i < n_items[d]) ? m_stock[d][i] : 0;
        checks++;
        if (o_rs[d] !== 4'(exp_s)) begin
          errors++;
          $display("FAIL %s rd_stock dut%0d item%0d: got %0d want %0d", tag, d, i, o_rs[d], exp_s);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({o_rdy[d], o_done[d]} !== 2'b10 || o_total[d] !== 8'(m_total[d]) ||
          o_line[d] !== 8'(m_line[d])) begin
        errors++;
        $display("FAIL %s idle dut%0d: got rdy=%0d done=%0d total=%0d line=%0d want rdy=1 done=0 total=%0d line=%0d",
                 tag, d, o_rdy[d], o_done[d], o_total[d], o_line[d], m_total[d], m_line[d]);
      end
    end
    @(negedge clk);
  endtask

  task automatic cfg_write(input int item, input int price, input int stock);
    cfg_we = 1'b1; cfg_item = 2'(item); cfg_price = 4'(price); cfg_stock = 4'(stock);
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (item < n_items[d]) begin
        m_price[d][item] = price;
        m_stock[d][item] = stock;
      end
    end
    $display("cfg   item=%0d price=%0d stock=%0d", item, price, stock);
  endtask

  task automatic clear_total();
    clr_total = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_total = 1'b0;
    for (int d = 0; d < 2; d++) m_total[d] = 0;
    $display("clear total");
  endtask

  // cfg_mode: 0 none, 1 cfg_we/clr_total together with the offered order,
  // 2 cfg_we/clr_total while the engine is busy. All must be ignored.
  task automatic do_order(input int mode, input int item, input int qty, input int cfg_mode);
    int         x_line[2];
    logic [3:0] x_err [2];
    int         exp_s;
    for (int d = 0; d < 2; d++) begin
      x_err[d] = 4'b0000;
      if (item >= n_items[d]) begin
        x_err[d]  = 4'b1000;
        x_line[d] = 0;
      end else begin
        x_line[d] = m_price[d][item] * qty;
        if (mode == 0) begin
          if (qty > m_stock[d][item])              x_err[d] = 4'b0100;
          else if (m_total[d] + x_line[d] > 255)   x_err[d] = 4'b0010;
        end else begin
          if (m_stock[d][item] + qty > 15)         x_err[d] = 4'b0100;
          else if (x_line[d] > m_total[d])         x_err[d] = 4'b0001;
        end
        if (x_err[d] == 4'b0000) begin
          if (mode == 0) begin
            m_total[d] += x_line[d];
            m_stock[d][item] -= qty;
          end else begin
            m_total[d] -= x_line[d];
            m_stock[d][item] += qty;
          end
        end
      end
      m_line[d] = x_line[d];
    end

    op_valid = 1'b1; op_mode = 1'(mode); op_item = 2'(item); op_qty = 4'(qty);
    rd_item  = 2'(item);
    if (cfg_mode == 1) begin
      cfg_we = 1'b1; clr_total = 1'b1; cfg_item = 2'(item);
      cfg_price = 4'($urandom); cfg_stock = 4'($urandom);
    end
    @(posedge clk);  // accept edge
    @(negedge clk);
    op_valid = 1'b0;
    op_mode  = 1'($urandom); op_item = 2'($urandom); op_qty = 4'($urandom);
    if (cfg_mode != 0) begin
      cfg_we = 1'b1; clr_total = 1'b1; cfg_item = 2'($urandom);
      cfg_price = 4'($urandom); cfg_stock = 4'($urandom);
    end
    for (int e = 1; e <= QW; e++) begin
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({o_rdy[d], o_done[d]} !== 2'b00) begin
          errors++;
          $display("FAIL busy dut%0d edge%0d: got rdy=%0d done=%0d want rdy=0 done=0", d, e, o_rdy[d], o_done[d]);
        end
      end
    end
    cfg_we = 1'b0; clr_total = 1'b0;
    @(posedge clk);  // completion edge
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({o_rdy[d], o_done[d], o_ei[d], o_es[d], o_eo[d], o_eu[d]} !== {2'b11, x_err[d]}) begin
        errors++;
        $display("FAIL flags dut%0d: got rdy,done,item,stock,ovf,unf=%b%b%b%b%b%b want 11%b",
                 d, o_rdy[d], o_done[d], o_ei[d], o_es[d], o_eo[d], o_eu[d], x_err[d]);
      end
      checks++;
      if (o_line[d] !== 8'(x_line[d])) begin
        errors++;
        $display("FAIL line dut%0d: got %0d want %0d", d, o_line[d], x_line[d]);
      end
      checks++;
      if (o_total[d] !== 8'(m_total[d])) begin
        errors++;
        $display("FAIL total dut%0d: got %0d want %0d", d, o_total[d], m_total[d]);
      end
      exp_s = (item < n_items[d]) ? m_stock[d][item] : 0;
      checks++;
      if (o_rs[d] !== 4'(exp_s)) begin
        errors++;
        $display("FAIL stock dut%0d: got %0d want %0d", d, o_rs[d], exp_s);
      end
    end
    $display("order mode=%0d item=%0d qty=%0d cfg=%0d line=%0d/%0d total=%0d/%0d err=%b/%b",
             mode, item, qty, cfg_mode, x_line[0], x_line[1], m_total[0], m_total[1], x_err[0], x_err[1]);
  endtask

  task automatic test_reset();
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_state("reset_held");
    reset_n = 1'b1;
    check_idle_state("reset_released");
  endtask

  task automatic test_directed();
    cfg_write(2, 5, 9);
    do_order(0, 2, 3, 0);
    checks++;
    if (o_total[0] !== 8'd15 || o_line[0] !== 8'd15 || o_rs[0] !== 4'd6) begin
      errors++;
      $display("FAIL first_sell: got total=%0d line=%0d stock=%0d want 15 15 6", o_total[0], o_line[0], o_rs[0]);
    end
    do_order(0, 2, 7, 0);
    cfg_write(0, 15, 15);
    do_order(0, 0, 15, 0);
    checks++;
    if (o_total[0] !== 8'd240) begin
      errors++;
      $display("FAIL big_sell: got total=%0d want 240", o_total[0]);
    end
    do_order(0, 2, 2, 0);
    do_order(0, 2, 2, 0);
    checks++;
    if (o_eo[0] !== 1'b1 || o_total[0] !== 8'd250 || o_rs[0] !== 4'd4) begin
      errors++;
      $display("FAIL ovf_sell: got ovf=%0d total=%0d stock=%0d want 1 250 4", o_eo[0], o_total[0], o_rs[0]);
    end
    do_order(1, 2, 1, 0);
    clear_total();
    do_order(1, 2, 1, 0);
    checks++;
    if (o_eu[0] !== 1'b1 || o_total[0] !== 8'd0 || o_rs[0] !== 4'd5) begin
      errors++;
      $display("FAIL unf_refund: got unf=%0d total=%0d stock=%0d want 1 0 5", o_eu[0], o_total[0], o_rs[0]);
    end
    check_idle_state("directed");
  endtask

  task automatic test_item_and_cfg();
    do_order(0, 3, 2, 0);
    checks++;
    if (o_ei[1] !== 1'b1 || o_line[1] !== 8'd0) begin
      errors++;
      $display("FAIL item_range: got err_item=%0d line=%0d want 1 0", o_ei[1], o_line[1]);
    end
    do_order(0, 2, 1, 1);
    do_order(0, 2, 0, 0);
    do_order(1, 2, 1, 2);
    check_idle_state("cfg_collision");
  endtask

  task automatic test_reset_abort();
    cfg_write(2, 5, 9);
    op_valid = 1'b1; op_mode = 1'b0; op_item = 2'd2; op_qty = 4'd1;
    @(posedge clk);  // edge 0
    @(negedge clk);
    op_valid = 1'b0;
    @(posedge clk);  // edge 1
    @(negedge clk);
    reset_n = 1'b0;  // sampled on edge 2
    for (int c = 0; c < QW + 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) reset_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_done[d] !== 1'b0) begin
          errors++;
          $display("FAIL abort_done dut%0d cycle%0d: got %0d want 0", d, c, o_done[d]);
        end
      end
    end
    $display("reset during order");
    model_reset();
    check_idle_state("abort");
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 9))
        0, 1:    cfg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        2:       clear_total();
        default: do_order(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      endcase
      if (k % 25 == 24) check_idle_state("random");
    end
  endtask

  initial begin
    reset_n = 1'b0; op_valid = 1'b0; op_mode = 1'b0; op_item = '0; op_qty = '0;
    cfg_we = 1'b0; cfg_item = '0; cfg_price = '0; cfg_stock = '0;
    clr_total = 1'b0; rd_item = '0;
    test_reset();
    test_directed();
    test_item_and_cfg();
    test_reset_abort();
    test_random(300);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
